// File: rtl/llc_lookup_way_pipe.sv
// LLC way-lookup stage: hit / empty / victim selection over a power-of-two way count,
// with lock-aware victim choice, registered output plus one-entry skid, flush and statistics.
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef VALID
`define VALID 3'd1
`endif
`ifndef SD
`define SD 3'd2
`endif

module llc_lookup_way_pipe #(
  parameter int unsigned WAYS       = 16,
  parameter int unsigned WAY_BITS   = 4,
  parameter int unsigned TAG_BITS   = 16,
  parameter int unsigned SET_BITS   = 10,
  parameter int unsigned STATE_BITS = 3,
  parameter int unsigned LOCK_EN    = 1,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [TAG_BITS-1:0]            in_tag,
  input  logic [SET_BITS-1:0]            in_set,
  input  logic [WAYS*TAG_BITS-1:0]       in_tags,
  input  logic [WAYS*STATE_BITS-1:0]     in_states,
  input  logic [WAY_BITS-1:0]            in_evict_way,
  input  logic [WAYS-1:0]                in_lock_mask,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WAY_BITS-1:0]            out_way,
  output logic                           out_hit,
  output logic                           out_evict,
  output logic                           out_no_victim,
  output logic [TAG_BITS+SET_BITS-1:0]   out_evict_addr,
  input  logic                           cnt_clr,
  output logic [CNT_BITS-1:0]            cnt_hit,
  output logic [CNT_BITS-1:0]            cnt_miss,
  output logic [CNT_BITS-1:0]            cnt_evict
);

  typedef struct packed {
    logic [WAY_BITS-1:0]          way;
    logic                         hit;
    logic                         evict;
    logic                         no_victim;
    logic [TAG_BITS+SET_BITS-1:0] addr;
  } res_t;

  logic [WAYS-1:0]     lock, hit_v, empty_v, valid_v, nsd_v;
  logic [WAY_BITS-1:0] sel_way, w;
  logic                sel_hit, sel_evict, sel_nov, found;
  logic [TAG_BITS-1:0] sel_tag;
  res_t                new_res, out_r, skid_r;
  logic                skid_full, accept, cnt_acc;

  assign lock = (LOCK_EN != 0) ? in_lock_mask : '0;

  always_comb begin
    hit_v   = '0;
    empty_v = '0;
    valid_v = '0;
    nsd_v   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      hit_v[i]   = (in_tags[TAG_BITS*i +: TAG_BITS] == in_tag) &&
                   (in_states[STATE_BITS*i +: STATE_BITS] != STATE_BITS'(`INVALID));
      empty_v[i] = (in_states[STATE_BITS*i +: STATE_BITS] == STATE_BITS'(`INVALID)) && !lock[i];
      valid_v[i] = (in_states[STATE_BITS*i +: STATE_BITS] == STATE_BITS'(`VALID)) && !lock[i];
      nsd_v[i]   = (in_states[STATE_BITS*i +: STATE_BITS] != STATE_BITS'(`SD)) && !lock[i];
    end
  end

  // Defaults describe the no-victim fallback; each scan below overrides only if nothing earlier matched.
  always_comb begin
    sel_way   = in_evict_way;
    sel_hit   = 1'b0;
    sel_evict = 1'b1;
    sel_nov   = 1'b1;
    found     = 1'b0;
    w         = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!found && hit_v[i]) begin
        sel_way = WAY_BITS'(i); sel_hit = 1'b1; sel_evict = 1'b0; sel_nov = 1'b0; found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!found && empty_v[i]) begin
        sel_way = WAY_BITS'(i); sel_evict = 1'b0; sel_nov = 1'b0; found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < WAYS; j++) begin
      w = in_evict_way + WAY_BITS'(j);
      if (!found && valid_v[w]) begin
        sel_way = w; sel_nov = 1'b0; found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < WAYS; j++) begin
      w = in_evict_way + WAY_BITS'(j);
      if (!found && nsd_v[w]) begin
        sel_way = w; sel_nov = 1'b0; found = 1'b1;
      end
    end
  end

  assign sel_tag = in_tags[TAG_BITS*sel_way +: TAG_BITS];

  always_comb begin
    new_res           = '0;
    new_res.way       = sel_way;
    new_res.hit       = sel_hit;
    new_res.evict     = sel_evict;
    new_res.no_victim = sel_nov;
    new_res.addr      = {sel_tag, in_set};
  end

  assign in_ready = !skid_full;
  assign accept   = in_valid && in_ready;
  assign cnt_acc  = accept && !flush;

  // Accept and drain-from-skid cannot coincide: the skid is full only while in_ready is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_r     <= '0;
      skid_r    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_r     <= new_res;
        out_valid <= 1'b1;
      end else begin
        skid_r    <= new_res;
        skid_full <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      if (skid_full) begin
        out_r     <= skid_r;
        skid_full <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_way        = out_r.way;
  assign out_hit        = out_r.hit;
  assign out_evict      = out_r.evict;
  assign out_no_victim  = out_r.no_victim;
  assign out_evict_addr = out_r.addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_hit   <= '0;
      cnt_miss  <= '0;
      cnt_evict <= '0;
    end else if (cnt_clr) begin
      cnt_hit   <= '0;
      cnt_miss  <= '0;
      cnt_evict <= '0;
    end else if (cnt_acc) begin
      if (sel_hit && cnt_hit != '1)
        cnt_hit <= cnt_hit + CNT_BITS'(1);
      if (!sel_hit && cnt_miss != '1)
        cnt_miss <= cnt_miss + CNT_BITS'(1);
      if (sel_evict && cnt_evict != '1)
        cnt_evict <= cnt_evict + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_llc_lookup_way_pipe.sv
// Bench for llc_lookup_way_pipe: two instances (locks on / locks off with narrow counters)
// checked every cycle against a queue-based model, plus directed literal expectations.
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef VALID
`define VALID 3'd1
`endif
`ifndef SD
`define SD 3'd2
`endif

module tb_llc_lookup_way_pipe;
  localparam logic [2:0] S_INV = `INVALID;
  localparam logic [2:0] S_VAL = `VALID;
  localparam logic [2:0] S_SD  = `SD;
  localparam logic [2:0] S_OTH = 3'd5;
  localparam int MAXA = 65535;
  localparam int MAXB = 15;

  typedef struct packed {
    logic [3:0]  way;
    logic        hit;
    logic        evict;
    logic        nov;
    logic [25:0] addr;
  } res_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, cnt_clr;
  logic [15:0]  in_tag;
  logic [9:0]   in_set;
  logic [255:0] in_tags;
  logic [47:0]  in_states;
  logic [3:0]   in_evict_way;
  logic [15:0]  in_lock_mask;

  logic        rdy_a, vld_a, hit_a, ev_a, nov_a, rdy_b, vld_b, hit_b, ev_b, nov_b;
  logic [3:0]  way_a, way_b;
  logic [25:0] addr_a, addr_b;
  logic [15:0] ch_a, cm_a, ce_a;
  logic [3:0]  ch_b, cm_b, ce_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  res_t qa[$];
  res_t qb[$];
  int mh_a, mm_a, me_a, mh_b, mm_b, me_b;

  always #5 clk = ~clk;

  llc_lookup_way_pipe #(.WAYS(16), .WAY_BITS(4), .TAG_BITS(16), .SET_BITS(10),
    .STATE_BITS(3), .LOCK_EN(1), .CNT_BITS(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_tag(in_tag), .in_set(in_set), .in_tags(in_tags), .in_states(in_states),
    .in_evict_way(in_evict_way), .in_lock_mask(in_lock_mask), .out_valid(vld_a),
    .out_ready(out_ready), .out_way(way_a), .out_hit(hit_a), .out_evict(ev_a),
    .out_no_victim(nov_a), .out_evict_addr(addr_a), .cnt_clr(cnt_clr),
    .cnt_hit(ch_a), .cnt_miss(cm_a), .cnt_evict(ce_a));

  llc_lookup_way_pipe #(.WAYS(16), .WAY_BITS(4), .TAG_BITS(16), .SET_BITS(10),
    .STATE_BITS(3), .LOCK_EN(0), .CNT_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_tag(in_tag), .in_set(in_set), .in_tags(in_tags), .in_states(in_states),
    .in_evict_way(in_evict_way), .in_lock_mask(in_lock_mask), .out_valid(vld_b),
    .out_ready(out_ready), .out_way(way_b), .out_hit(hit_b), .out_evict(ev_b),
    .out_no_victim(nov_b), .out_evict_addr(addr_b), .cnt_clr(cnt_clr),
    .cnt_hit(ch_b), .cnt_miss(cm_b), .cnt_evict(ce_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference selection: walk the priority list, first rule that yields a way wins.
  function automatic res_t ref_sel(input logic [15:0] tag, input logic [9:0] set,
                                   input logic [255:0] tags, input logic [47:0] sts,
                                   input logic [3:0] ew, input logic [15:0] lk, input bit use_lock);
    res_t r;
    bit found;
    int w;
    logic [2:0] st;
    bit locked;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++)
      if (!found && sts[3*i +: 3] != S_INV && tags[16*i +: 16] == tag) begin
        found = 1'b1; r.way = 4'(i); r.hit = 1'b1;
      end
    for (int i = 0; i < 16; i++)
      if (!found && sts[3*i +: 3] == S_INV && !(use_lock && lk[i])) begin
        found = 1'b1; r.way = 4'(i);
      end
    for (int pass = 0; pass < 2; pass++)
      for (int j = 0; j < 16; j++) begin
        w = (int'(ew) + j) % 16;
        st = sts[3*w +: 3];
        locked = use_lock && lk[w];
        if (!found && !locked && ((pass == 0) ? (st == S_VAL) : (st != S_SD))) begin
          found = 1'b1; r.way = 4'(w); r.evict = 1'b1;
        end
      end
    if (!found) begin
      r.way = ew; r.evict = 1'b1; r.nov = 1'b1;
    end
    r.addr = {tags[16*r.way +: 16], set};
    return r;
  endfunction

  always @(posedge clk) begin
    res_t ra, rb;
    bit acc;
    ra  = ref_sel(in_tag, in_set, in_tags, in_states, in_evict_way, in_lock_mask, 1'b1);
    rb  = ref_sel(in_tag, in_set, in_tags, in_states, in_evict_way, in_lock_mask, 1'b0);
    acc = in_valid && (qa.size() < 2);
    if (!rst) begin
      qa.delete(); qb.delete();
      mh_a = 0; mm_a = 0; me_a = 0; mh_b = 0; mm_b = 0; me_b = 0;
    end else begin
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (qa.size() > 0 && out_ready) begin
          void'(qa.pop_front()); void'(qb.pop_front());
        end
        if (acc) begin
          qa.push_back(ra); qb.push_back(rb);
        end
      end
      if (cnt_clr) begin
        mh_a = 0; mm_a = 0; me_a = 0; mh_b = 0; mm_b = 0; me_b = 0;
      end else if (acc && !flush) begin
        if (ra.hit) mh_a = (mh_a < MAXA) ? mh_a + 1 : mh_a;
        else        mm_a = (mm_a < MAXA) ? mm_a + 1 : mm_a;
        if (ra.evict) me_a = (me_a < MAXA) ? me_a + 1 : me_a;
        if (rb.hit) mh_b = (mh_b < MAXB) ? mh_b + 1 : mh_b;
        else        mm_b = (mm_b < MAXB) ? mm_b + 1 : mm_b;
        if (rb.evict) me_b = (me_b < MAXB) ? me_b + 1 : me_b;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready_a", rdy_a, qa.size() < 2);
      chk("in_ready_b", rdy_b, qb.size() < 2);
      chk("out_valid_a", vld_a, qa.size() > 0);
      chk("out_valid_b", vld_b, qb.size() > 0);
      if (qa.size() > 0) begin
        chk("res_a", {way_a, hit_a, ev_a, nov_a, addr_a}, qa[0]);
        chk("res_b", {way_b, hit_b, ev_b, nov_b, addr_b}, qb[0]);
      end
      chk("cnt_hit_a", ch_a, mh_a);
      chk("cnt_miss_a", cm_a, mm_a);
      chk("cnt_evict_a", ce_a, me_a);
      chk("cnt_hit_b", ch_b, mh_b);
      chk("cnt_miss_b", cm_b, mm_b);
      chk("cnt_evict_b", ce_b, me_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_way(input int i, input logic [15:0] tg, input logic [2:0] st);
    in_tags[16*i +: 16] = tg;
    in_states[3*i +: 3] = st;
  endtask

  task automatic all_ways(input logic [15:0] tg, input logic [2:0] st);
    for (int i = 0; i < 16; i++) set_way(i, tg, st);
  endtask

  task automatic send();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_tag = '0; in_set = '0; in_tags = '0; in_states = '0; in_evict_way = '0; in_lock_mask = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", rdy_a, 1'b1);
    chk("rst_out_valid", vld_a, 1'b0);
    chk("rst_fields", {way_a, hit_a, ev_a, nov_a, addr_a}, 64'h0);
    chk("rst_counters", {ch_a, cm_a, ce_a}, 64'h0);

    // Single hit at way 5
    step();
    all_ways(16'h7777, S_INV);
    set_way(5, 16'h1234, S_VAL);
    in_tag = 16'h1234; in_set = 10'h155;
    send();
    chk("hit_way", way_a, 4'd5);
    chk("hit_flags", {vld_a, hit_a, ev_a, nov_a}, 4'b1100);
    chk("hit_cnt", ch_a, 16'd1);

    // Empty-way selection, lock on way 3
    step();
    all_ways(16'hAAAA, S_VAL);
    set_way(3, 16'hAAAA, S_INV);
    set_way(7, 16'hAAAA, S_INV);
    in_lock_mask = 16'h0008;
    send();
    chk("empty_way_a", way_a, 4'd7);
    chk("empty_way_b", way_b, 4'd3);
    chk("empty_flags", {hit_a, ev_a, nov_a}, 3'b000);
    chk("empty_miss_cnt", cm_a, 16'd1);

    // Rotating victim scan from 14 past SD and locked ways
    step();
    all_ways(16'hAAAA, S_VAL);
    set_way(1, 16'hBEEF, S_VAL);
    set_way(14, 16'hAAAA, S_SD);
    set_way(15, 16'hAAAA, S_SD);
    in_lock_mask = 16'h0001; in_evict_way = 4'd14; in_set = 10'h2C3;
    send();
    chk("evict_way_a", way_a, 4'd1);
    chk("evict_way_b", way_b, 4'd0);
    chk("evict_flags", {hit_a, ev_a, nov_a}, 3'b010);
    chk("evict_addr", addr_a, {16'hBEEF, 10'h2C3});
    chk("evict_cnt", ce_a, 16'd1);

    // All SD: fallback to the start pointer
    step();
    all_ways(16'hAAAA, S_SD);
    in_lock_mask = '0; in_evict_way = 4'd9;
    send();
    chk("novict_way", way_a, 4'd9);
    chk("novict_flags", {hit_a, ev_a, nov_a}, 3'b011);
    chk("novict_cnts", {cm_a, ce_a}, {16'd3, 16'd2});

    // Back-to-back A,B,C with consumer stalled
    step();
    all_ways(16'h0000, S_INV);
    set_way(2, 16'h0002, S_VAL);
    set_way(4, 16'h0004, S_VAL);
    set_way(6, 16'h0006, S_VAL);
    in_evict_way = 4'd0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tag = 16'h0002; step();
    in_tag = 16'h0004; step();
    in_tag = 16'h0006; step();
    step();
    @(negedge clk);
    chk("stall_in_ready", rdy_a, 1'b0);
    chk("stall_head", {vld_a, way_a}, {1'b1, 4'd2});
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_tail", {vld_a, way_a}, {1'b1, 4'd6});

    // Flush with output and skid full and a request pending
    step();
    out_ready = 1'b0;
    in_tag = 16'h0002;
    in_valid = 1'b1;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {vld_a, rdy_a}, 2'b01);
    chk("flush_cnt_hit", ch_a, 16'd6);
    step();
    flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop", {vld_a, ch_a}, {1'b0, 16'd6});
    step();
    out_ready = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      rst       = (n != 1500);
      in_tag    = 16'($urandom_range(0, 5));
      in_set    = 10'($urandom);
      in_evict_way = 4'($urandom);
      in_lock_mask = 16'($urandom) & 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: set_way(i, 16'($urandom_range(0, 40)), S_INV);
          1: set_way(i, 16'($urandom_range(0, 40)), S_VAL);
          2: set_way(i, 16'($urandom_range(0, 40)), S_SD);
          default: set_way(i, 16'($urandom_range(0, 40)), S_OTH);
        endcase
      end
      step();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; rst = 1'b1; out_ready = 1'b1;

    // Saturation on the narrow-counter instance
    all_ways(16'hAAAA, S_VAL);
    in_tag = 16'h1234; in_lock_mask = '0;
    in_valid = 1'b1;
    repeat (20) step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_miss_b", cm_b, 4'hF);
    chk("sat_evict_b", ce_b, 4'hF);

    // Clear wins over a simultaneous hit
    step();
    set_way(5, 16'h1234, S_VAL);
    cnt_clr = 1'b1;
    send();
    cnt_clr = 1'b0;
    chk("clr_hit", {ch_a, ch_b}, 20'h0);
    chk("clr_miss_b", cm_b, 4'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/llc_lookup_way_pipe.md
Name: llc_lookup_way_pipe

Overview:
- Parametrised successor of the LLC way-lookup stage. It sits between the tag/state memory read pipeline register and the LLC process stage.
- Resolves hit, empty-way and eviction-victim selection for any power-of-two way count.
- Honours a per-way lock mask so ways with in-flight transactions are never chosen as victims.
- Output is registered with a one-entry skid buffer for full-throughput valid/ready, plus flush support and saturating hit/miss/evict statistics counters.

Parameters:
WAYS, 16, number of ways; power of two, minimum 2
WAY_BITS, 4, log2(WAYS)
TAG_BITS, 16, tag width
SET_BITS, 10, set index width
STATE_BITS, 3, per-way state width; encodings are the codebase `INVALID / `VALID / `SD constants
LOCK_EN, 1, when 0 the lock mask is ignored (treated as all zero)
CNT_BITS, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
flush  in  1  drop all buffered and accepted-this-cycle lookups
in_valid  in  1  lookup request valid
in_ready  out  1  block can accept a request
in_tag  in  TAG_BITS  requested tag
in_set  in  SET_BITS  requested set
in_tags  in  WAYS*TAG_BITS  way i tag at [TAG_BITS*(i+1)-1 -: TAG_BITS]
in_states  in  WAYS*STATE_BITS  way i state at the same slicing scheme
in_evict_way  in  WAY_BITS  rotating eviction start pointer
in_lock_mask  in  WAYS  bit i=1: way i locked, not a victim
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_way  out  WAY_BITS  selected way
out_hit  out  1  tag hit
out_evict  out  1  selected way must be evicted
out_no_victim  out  1  no unlocked/non-SD candidate; fallback used
out_evict_addr  out  TAG_BITS+SET_BITS  {tag of out_way, in_set}
cnt_clr  in  1  clear statistics
cnt_hit, cnt_miss, cnt_evict  out  CNT_BITS each  saturating counters

Behaviour:
- Reset (rst=0 at posedge): out_valid=0, skid empty, all out_* fields 0, counters 0. in_ready=1 in the first cycle after reset. A reset asserted mid-transfer discards all pending results.
- Selection, combinational on the input. hit_i = tag_i==in_tag && state_i!=`INVALID. empty_i = state_i==`INVALID && !lock_i.
- Priority:
  1. Any hit: lowest-index hit way; out_hit=1, out_evict=0. Locks are ignored for hits.
  2. Any empty: lowest-index empty way; out_evict=0.
  3. Scan j=0..WAYS-1 over w=(in_evict_way+j) mod WAYS. Pick the first w with state==`VALID && !lock; out_evict=1.
  4. Same scan, first w with state!=`SD && !lock; out_evict=1.
  5. Otherwise w=in_evict_way, out_evict=1, out_no_victim=1.
- out_no_victim=0 for priorities 1-4. Way addition wraps modulo WAYS (truncate to WAY_BITS).
- Handshake:
  - Accept = in_valid && in_ready. in_ready = !skid_full, a registered value that does not depend on out_ready.
  - Latency: the result appears on the out_* ports 1 cycle after accept.
  - On accept: if output register empty or out_ready=1, the result loads into the output register. Otherwise it loads into the skid.
  - When output drains (out_valid && out_ready) and the skid is full, the skid moves to the output register and the skid empties. Same-cycle accept with drain and full skid is impossible because in_ready=0.
  - Order is strictly FIFO. Out fields hold stable while out_valid && !out_ready.
- Flush (synchronous, flush=1): next cycle out_valid=0 and skid empty. A request accepted in the flush cycle is dropped and not counted. in_ready=1 the cycle after flush. Flush has priority over every load and drain.
- Counters:
  - Update on accept (not on output), only when flush=0.
  - hit → cnt_hit+1. Non-hit → cnt_miss+1. Additionally out_evict=1 → cnt_evict+1.
  - Counters saturate at all-ones. cnt_clr has priority: the counter is 0 next cycle even if it would also increment.

Test Plan:
- WAYS=16, way 5 tag=0x1234 `VALID, in_tag=0x1234, all others `INVALID → out_way=5, out_hit=1, out_evict=0, 1 cycle after accept; cnt_hit=1.
- No hit, ways 3 and 7 `INVALID, lock_mask bit3=1 → out_way=7, out_evict=0; with LOCK_EN=0 → out_way=3.
- No hit/empty, in_evict_way=14, ways 14,15 `SD, way 0 `VALID locked, way 1 `VALID → out_way=1, out_evict=1, out_evict_addr={tag1,in_set}, cnt_evict=1.
- All ways `SD → out_way=in_evict_way, out_evict=1, out_no_victim=1.
- Back-to-back requests A,B,C with out_ready=0 → A held, B in skid, in_ready=0, C stalls. Raise out_ready → A,B,C emerge in order, with no bubble after the skid drains.
- Flush with output and skid full and in_valid=1 → out_valid=0 next cycle, counters unchanged. Then: preload cnt_miss to all-ones, another miss → stays all-ones. cnt_clr together with a hit → cnt_hit=0.
